// File: rtl/hdmi_tx_pkg.sv
// Shared HDMI transmitter definitions: period codes, preamble values, guard-band lengths
// and the default 720x480@60 raster timing.
package hdmi_tx_pkg;

    localparam int unsigned POS_W   = 12;
    localparam int unsigned PHASE_W = 5;

    typedef enum logic [2:0] {
        P_CTRL    = 3'd0,
        P_VID_PRE = 3'd1,
        P_VID_GB  = 3'd2,
        P_VIDEO   = 3'd3,
        P_DI_PRE  = 3'd4,
        P_DI_LGB  = 3'd5,
        P_DI_DATA = 3'd6,
        P_DI_TGB  = 3'd7
    } period_e;

    typedef enum logic [2:0] {
        ISL_IDLE,
        ISL_PRE,
        ISL_LGB,
        ISL_DATA,
        ISL_TGB
    } island_e;

    localparam logic [3:0] CTL_VIDEO  = 4'b0001;
    localparam logic [3:0] CTL_ISLAND = 4'b0101;

    localparam int unsigned PRE_LEN        = 8;
    localparam int unsigned GB_LEN         = 2;
    localparam int unsigned PKT_LEN        = 32;
    localparam int unsigned VID_LEADER_LEN = PRE_LEN + GB_LEN;
    localparam int unsigned MIN_CTRL_LEN   = 12;

    localparam int unsigned DEF_H_ACTIVE = 720;
    localparam int unsigned DEF_H_FRONT  = 16;
    localparam int unsigned DEF_H_SYNC   = 62;
    localparam int unsigned DEF_H_TOTAL  = 858;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FRONT  = 9;
    localparam int unsigned DEF_V_SYNC   = 6;
    localparam int unsigned DEF_V_TOTAL  = 525;

endpackage

// File: rtl/hdmi_raster_counter.sv
// Raster position counters with syncs and frame pulse; outputs describe the pixel at hPos/vPos.
// hNext_c/vNext_c expose the coordinates being loaded so peer logic can register coherent outputs.
module hdmi_raster_counter
    import hdmi_tx_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FRONT  = DEF_H_FRONT,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_TOTAL  = DEF_H_TOTAL,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FRONT  = DEF_V_FRONT,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_TOTAL  = DEF_V_TOTAL,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic             pixelClock,
    input  logic             reset,
    output logic [POS_W-1:0] hPos,
    output logic [POS_W-1:0] vPos,
    output logic [POS_W-1:0] hNext_c,
    output logic [POS_W-1:0] vNext_c,
    output logic             hSync,
    output logic             vSync,
    output logic             frameStart
);

    localparam logic [POS_W-1:0] H_LAST   = POS_W'(H_TOTAL - 1);
    localparam logic [POS_W-1:0] V_LAST   = POS_W'(V_TOTAL - 1);
    localparam logic [POS_W-1:0] HS_FIRST = POS_W'(H_ACTIVE + H_FRONT);
    localparam logic [POS_W-1:0] HS_LAST  = POS_W'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam logic [POS_W-1:0] VS_FIRST = POS_W'(V_ACTIVE + V_FRONT);
    localparam logic [POS_W-1:0] VS_LAST  = POS_W'(V_ACTIVE + V_FRONT + V_SYNC - 1);

    // First edge after reset loads pixel (0,0) rather than advancing past it
    logic running;

    always_comb begin
        hNext_c = '0;
        vNext_c = '0;
        if (running) begin
            if (hPos == H_LAST) begin
                hNext_c = '0;
                vNext_c = (vPos == V_LAST) ? '0 : vPos + POS_W'(1);
            end else begin
                hNext_c = hPos + POS_W'(1);
                vNext_c = vPos;
            end
        end
    end

    always_ff @(posedge pixelClock or posedge reset) begin
        if (reset) begin
            running    <= 1'b0;
            hPos       <= '0;
            vPos       <= '0;
            hSync      <= ~SYNC_POL;
            vSync      <= ~SYNC_POL;
            frameStart <= 1'b0;
        end else begin
            running    <= 1'b1;
            hPos       <= hNext_c;
            vPos       <= vNext_c;
            hSync      <= (hNext_c >= HS_FIRST && hNext_c <= HS_LAST) ? SYNC_POL : ~SYNC_POL;
            vSync      <= (vNext_c >= VS_FIRST && vNext_c <= VS_LAST) ? SYNC_POL : ~SYNC_POL;
            frameStart <= (hNext_c == '0) && (vNext_c == '0);
        end
    end

endmodule

// File: rtl/hdmi_period_scheduler.sv
// HDMI period sequencer: names the period of every pixel, drives CTL[3:0] and grants one
// data-island slot per line to the packetizer via pktValid/pktAccept.
module hdmi_period_scheduler
    import hdmi_tx_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
    parameter int unsigned H_FRONT   = DEF_H_FRONT,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_TOTAL   = DEF_H_TOTAL,
    parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
    parameter int unsigned V_FRONT   = DEF_V_FRONT,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_TOTAL   = DEF_V_TOTAL,
    parameter bit          SYNC_POL  = 1'b0,
    parameter int unsigned DI_OFFSET = 4,
    parameter int unsigned MAX_PKTS  = 2
) (
    input  logic               pixelClock,
    input  logic               reset,
    input  logic               pktValid,
    output logic               pktAccept,
    output logic [PHASE_W-1:0] pktPixel,
    output logic [2:0]         period,
    output logic [3:0]         ctl,
    output logic               hSync,
    output logic               vSync,
    output logic               de,
    output logic [POS_W-1:0]   hPos,
    output logic [POS_W-1:0]   vPos,
    output logic               frameStart
);

    localparam logic [POS_W-1:0]   DECISION_H = POS_W'(H_ACTIVE + DI_OFFSET - 1);
    localparam logic [POS_W-1:0]   VPRE_FIRST = POS_W'(H_TOTAL - VID_LEADER_LEN);
    localparam logic [POS_W-1:0]   VGB_FIRST  = POS_W'(H_TOTAL - GB_LEN);
    localparam logic [POS_W-1:0]   H_ACT      = POS_W'(H_ACTIVE);
    localparam logic [POS_W-1:0]   V_ACT      = POS_W'(V_ACTIVE);
    localparam logic [POS_W-1:0]   V_LAST     = POS_W'(V_TOTAL - 1);
    localparam logic [POS_W-1:0]   V_ACT_LAST = POS_W'(V_ACTIVE - 1);
    localparam logic [PHASE_W-1:0] PRE_LAST   = PHASE_W'(PRE_LEN - 1);
    localparam logic [PHASE_W-1:0] GB_LAST    = PHASE_W'(GB_LEN - 1);
    localparam logic [PHASE_W-1:0] PKT_LAST   = PHASE_W'(PKT_LEN - 1);
    localparam logic [1:0]         PKT_MAX    = 2'(MAX_PKTS);

    generate
        if ((H_ACTIVE + DI_OFFSET + PRE_LEN + 2 * GB_LEN + PKT_LEN * MAX_PKTS + MIN_CTRL_LEN
             > H_TOTAL - VID_LEADER_LEN) || (MAX_PKTS < 1) || (MAX_PKTS > 2)) begin : gBadParams
            $error("hdmi_period_scheduler: data island does not fit in horizontal blanking");
        end
    endgenerate

    logic [POS_W-1:0] hNext_c;
    logic [POS_W-1:0] vNext_c;

    hdmi_raster_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FRONT  (H_FRONT),
        .H_SYNC   (H_SYNC),
        .H_TOTAL  (H_TOTAL),
        .V_ACTIVE (V_ACTIVE),
        .V_FRONT  (V_FRONT),
        .V_SYNC   (V_SYNC),
        .V_TOTAL  (V_TOTAL),
        .SYNC_POL (SYNC_POL)
    ) uRaster (
        .pixelClock (pixelClock),
        .reset      (reset),
        .hPos       (hPos),
        .vPos       (vPos),
        .hNext_c    (hNext_c),
        .vNext_c    (vNext_c),
        .hSync      (hSync),
        .vSync      (vSync),
        .frameStart (frameStart)
    );

    // Video/control decode of the pixel about to be displayed; the island FSM overrides it
    period_e    vidPeriod_c;
    logic [3:0] vidCtl_c;
    logic       vidDe_c;
    logic       leaderLine_c;

    always_comb begin
        vidPeriod_c  = P_CTRL;
        vidCtl_c     = 4'b0000;
        vidDe_c      = 1'b0;
        leaderLine_c = (vNext_c == V_LAST) || (vNext_c < V_ACT_LAST);
        if (hNext_c < H_ACT && vNext_c < V_ACT) begin
            vidPeriod_c = P_VIDEO;
            vidDe_c     = 1'b1;
        end else if (leaderLine_c && hNext_c >= VGB_FIRST) begin
            vidPeriod_c = P_VID_GB;
        end else if (leaderLine_c && hNext_c >= VPRE_FIRST) begin
            vidPeriod_c = P_VID_PRE;
            vidCtl_c    = CTL_VIDEO;
        end
    end

    island_e           islandState;
    logic [PHASE_W-1:0] phase;
    logic [1:0]         pktCount;

    // Island FSM; phase is the index of the current pixel within the current state
    always_ff @(posedge pixelClock or posedge reset) begin
        if (reset) begin
            islandState <= ISL_IDLE;
            phase       <= '0;
            pktCount    <= '0;
            period      <= P_CTRL;
            ctl         <= 4'b0000;
            de          <= 1'b0;
            pktAccept   <= 1'b0;
            pktPixel    <= '0;
        end else begin
            period    <= vidPeriod_c;
            ctl       <= vidCtl_c;
            de        <= vidDe_c;
            pktAccept <= 1'b0;
            pktPixel  <= '0;
            case (islandState)
                ISL_IDLE: begin
                    if (hPos == DECISION_H && pktValid) begin
                        islandState <= ISL_PRE;
                        phase       <= '0;
                        pktCount    <= '0;
                        period      <= P_DI_PRE;
                        ctl         <= CTL_ISLAND;
                    end
                end
                ISL_PRE: begin
                    if (phase == PRE_LAST) begin
                        islandState <= ISL_LGB;
                        phase       <= '0;
                        period      <= P_DI_LGB;
                        ctl         <= 4'b0000;
                    end else begin
                        phase  <= phase + PHASE_W'(1);
                        period <= P_DI_PRE;
                        ctl    <= CTL_ISLAND;
                    end
                end
                ISL_LGB: begin
                    ctl <= 4'b0000;
                    if (phase == GB_LAST) begin
                        islandState <= ISL_DATA;
                        phase       <= '0;
                        pktCount    <= 2'd1;
                        pktAccept   <= 1'b1;
                        period      <= P_DI_DATA;
                    end else begin
                        phase  <= phase + PHASE_W'(1);
                        period <= P_DI_LGB;
                    end
                end
                ISL_DATA: begin
                    ctl <= 4'b0000;
                    if (phase != PKT_LAST) begin
                        phase    <= phase + PHASE_W'(1);
                        pktPixel <= phase + PHASE_W'(1);
                        period   <= P_DI_DATA;
                    end else if (pktValid && pktCount < PKT_MAX) begin
                        phase     <= '0;
                        pktCount  <= pktCount + 2'd1;
                        pktAccept <= 1'b1;
                        period    <= P_DI_DATA;
                    end else begin
                        islandState <= ISL_TGB;
                        phase       <= '0;
                        period      <= P_DI_TGB;
                    end
                end
                ISL_TGB: begin
                    if (phase == GB_LAST) begin
                        islandState <= ISL_IDLE;
                        phase       <= '0;
                    end else begin
                        phase  <= phase + PHASE_W'(1);
                        period <= P_DI_TGB;
                        ctl    <= 4'b0000;
                    end
                end
                default: begin
                    islandState <= ISL_IDLE;
                    phase       <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/hdmi_period_scheduler.md
Name: hdmi_period_scheduler

Overview:
Sequences the three TMDS encoder/serializer channels of the HDMI transmitter. It owns the 720x480@60 raster counters and generates hSync/vSync. Each pixel clock it names the HDMI period (control, video preamble/guard band, active video, data-island preamble/guard bands/packet) and drives CTL[3:0]. Once per line it grants a fixed data-island slot in horizontal blanking to the audio/InfoFrame packetizer through a valid/accept handshake.

Parameters:
H_ACTIVE, 720, active pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 62, hSync width (pixels)
H_TOTAL, 858, pixels per line including blanking
V_ACTIVE, 480, active lines
V_FRONT, 9, vertical front porch (lines)
V_SYNC, 6, vSync width (lines)
V_TOTAL, 525, lines per frame
SYNC_POL, 0, sync active level (0 = negative, CEA-861 480p)
DI_OFFSET, 4, pixels after H_ACTIVE at which the island preamble starts
MAX_PKTS, 2, maximum 32-pixel packets per island (1..2)

Ports:
pixelClock  in  1  pixel clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
pktValid  in  1  packetizer has a packet ready; held until accepted
pktAccept  out  1  one-cycle pulse on pixel 0 of each granted packet
pktPixel  out  5  pixel index 0..31 within the current packet
period  out  3  0 CTRL, 1 VID_PRE, 2 VID_GB, 3 VIDEO, 4 DI_PRE, 5 DI_LGB, 6 DI_DATA, 7 DI_TGB
ctl  out  4  {CTL3,CTL2,CTL1,CTL0} for the green/red channels
hSync  out  1  horizontal sync at SYNC_POL
vSync  out  1  vertical sync at SYNC_POL
de  out  1  high iff period==VIDEO
hPos  out  12  current pixel column 0..H_TOTAL-1
vPos  out  12  current line 0..V_TOTAL-1
frameStart  out  1  pulse when hPos==0 and vPos==0

Behaviour:
- Reset values: hPos=0, vPos=0, period=CTRL, ctl=0, de=0, pktAccept=0, pktPixel=0, hSync=vSync=~SYNC_POL, frameStart=0. An island in progress at reset is aborted with no completion. The packetizer re-arms on pktValid.
- All outputs are registered and mutually coherent. Every output describes the pixel at hPos/vPos in the same cycle. Latency to the encoders is 0.
- hPos counts 0..H_TOTAL-1 and wraps to 0. When it wraps, vPos increments and wraps at V_TOTAL-1. A frame is H_TOTAL*V_TOTAL cycles (450450 at defaults).
- hSync is active for hPos in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1], i.e. 736..797 at defaults.
- vSync is active for vPos in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC-1], i.e. 489..494, for the whole line.
- VIDEO: hPos<H_ACTIVE and vPos<V_ACTIVE.
- Video leader: on lines whose successor line is active (vPos==V_TOTAL-1, or vPos<V_ACTIVE-1):
  - VID_PRE for hPos H_TOTAL-10..H_TOTAL-3, with ctl=4'b0001.
  - VID_GB for hPos H_TOTAL-2..H_TOTAL-1, with ctl=0.
  - No video leader on line V_ACTIVE-1.
- Island decision: made at hPos==H_ACTIVE+DI_OFFSET-1 on every line, active or blanking. If pktValid=1, the island is committed. Otherwise the line has no island.
- Island FSM states: IDLE -> DI_PRE (8 px, ctl=4'b0101) -> DI_LGB (2 px) -> DI_DATA (32 px per packet) -> DI_TGB (2 px) -> IDLE.
  - ctl=0 in every island state except DI_PRE.
  - In DI_DATA, pktPixel counts 0..31. pktAccept=1 only when pktPixel==0.
  - At pktPixel==31: if pktValid=1 and the packet count is below MAX_PKTS, start the next packet. Otherwise go to DI_TGB.
- Default timing: preamble 724..731, LGB 732..733, packets 734..765 and 766..797, TGB 798..799 (or 766..767 if only one packet).
- pktValid is ignored outside the decision cycle and packet-end cycles.
- Simultaneous hSync and island is legal; sync levels stay valid on hSync/vSync throughout.
- Elaboration check: H_ACTIVE+DI_OFFSET+12+32*MAX_PKTS+12 <= H_TOTAL-10, which guarantees at least 12 control pixels before the video preamble. Illegal values fail elaboration via $error in a generate block.
- All other pixels are CTRL with ctl=0.

Decomposition:
- Shared package hdmi_tx_pkg contains:
  - period codes
  - preamble constants CTL_VIDEO=4'b0001 and CTL_ISLAND=4'b0101
  - guard-band/preamble lengths (8, 2, 32)
  - default 480p timing constants
- One sub-module, hdmi_raster_counter: hPos/vPos, hSync/vSync, frameStart.
- The island FSM and period/ctl decode stay in this block.

Test Plan:
- Reset held for 5 cycles, then released: all outputs at reset values. First frameStart at cycle 0, second at cycle 450450. hPos max 857, vPos max 524.
- pktValid=0 forever, line 10: VID_PRE with ctl=0001 at hPos 848..855, VID_GB at 856..857, VIDEO at 0..719. Line 479 has only CTRL after 719.
- pktValid held high on line 100: DI_PRE with ctl=0101 at 724..731. pktAccept pulses at 734 and 766. DI_TGB at 798..799, CTRL at 800.
- pktValid high at hPos 723, dropped before 765: single packet, DI_TGB at 766..767, pktAccept pulses exactly once.
- pktValid rises at hPos 724 (after the decision cycle): no island on that line. Island on the next line at 724.
- Async reset asserted at hPos 750 during DI_DATA: period=CTRL and pktAccept=0 immediately. After release, hPos restarts at 0 with no residual island.
